sdram_cmd_sequencer: RTL and testbench

SDRAM_CMD_SEQUENCER -- requirements
Module: sdram_cmd_sequencer

---
 rtl/sdram_seq_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/sdram_cmd_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sdram_cmd_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_seq_pkg.sv
// SDRAM command sequencer shared types.
// FSM state encoding and controller byte-address builder.
package sdram_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      READ_BEATS,
      WR_GAP
   } state_t;

   function automatic logic [31:0] byte_adr(
      input logic [30:0] i_addr
   );
      return {i_addr, 1'b0};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, one-hot grant.
// Search starts one past the last granted channel.
module rr_arbiter #(
   parameter int NUM_CH = 2,
   parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [NUM_CH-1:0] i_req,
   input  logic              i_en,
   output logic [NUM_CH-1:0] o_gnt,
   output logic [CW-1:0]     o_idx,
   output logic              o_any
);

   logic [CW-1:0] r_last;

   // pick first requester after r_last, wrapping
   always_comb begin
      int w_idx;
      w_idx = 0;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_idx = (int'(r_last) + 1 + i) % NUM_CH;
         if (!o_any && i_req[w_idx]) begin
            o_any        = 1'b1;
            o_gnt[w_idx] = 1'b1;
            o_idx        = CW'(w_idx);
         end
      end
   end

   // pointer moves only when a grant is taken
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_last <= CW'(NUM_CH - 1);
      else if (i_en && o_any)
         r_last <= o_idx;
   end

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// Multi-channel command sequencer for a simple SDRAM controller.
// One command in flight; read beats forwarded one cycle after capture.
module sdram_cmd_sequencer
   import sdram_seq_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int ADDR_WIDTH = 24,
   parameter int BURST_LEN  = 8,
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         sdram_clk,
   input  logic                         sdram_rst_n,
   input  logic [NUM_CH-1:0]            cmd_valid_i,
   output logic [NUM_CH-1:0]            cmd_ready_o,
   input  logic [NUM_CH-1:0]            cmd_we_i,
   input  logic [NUM_CH-1:0]            cmd_burst_i,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [NUM_CH*16-1:0]         cmd_data_i,
   input  logic [NUM_CH*2-1:0]          cmd_sel_i,
   input  logic [NUM_CH-1:0]            rsp_alm_full_i,
   output logic                         rsp_valid_o,
   output logic [CW-1:0]                rsp_ch_o,
   output logic [15:0]                  rsp_data_o,
   output logic                         rsp_last_o,
   input  logic                         sc_idle_i,
   input  logic                         sc_ack_i,
   input  logic [15:0]                  sc_dat_i,
   output logic                         sc_acc_o,
   output logic                         sc_we_o,
   output logic [31:0]                  sc_adr_o,
   output logic [15:0]                  sc_dat_o,
   output logic [1:0]                   sc_sel_o
);

   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

   state_t                r_state;
   state_t                w_next;
   logic                  w_grant;
   logic [NUM_CH-1:0]     w_elig;
   logic [NUM_CH-1:0]     w_gnt;
   logic [CW-1:0]         w_gidx;
   logic                  w_any;

   logic                  r_we;
   logic                  r_burst;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [15:0]           r_data;
   logic [1:0]            r_sel;
   logic [CW-1:0]         r_ch;
   logic [BW-1:0]         r_beat;
   logic [NUM_CH-1:0]     r_ready;
   logic                  r_acc;
   logic                  r_sc_we;
   logic [31:0]           r_adr;
   logic [15:0]           r_sc_dat;
   logic [1:0]            r_sc_sel;
   logic                  r_rsp_valid;
   logic [CW-1:0]         r_rsp_ch;
   logic [15:0]           r_rsp_data;
   logic                  r_rsp_last;

   // reads need reserved sink space, writes do not
   assign w_elig = cmd_valid_i & (cmd_we_i | ~rsp_alm_full_i);

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CW     (CW)
   ) u_arb (
      .i_clk   (sdram_clk),
      .i_rst_n (sdram_rst_n),
      .i_req   (w_elig),
      .i_en    (w_grant),
      .o_gnt   (w_gnt),
      .o_idx   (w_gidx),
      .o_any   (w_any)
   );

   // state register
   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // next-state decode
   always_comb begin
      w_next  = r_state;
      w_grant = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_grant = 1'b1;
               w_next  = ISSUE;
            end
         end
         ISSUE: begin
            if (sc_idle_i)
               w_next = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (sc_ack_i) begin
               if (r_we)
                  w_next = WR_GAP;
               else if (r_burst && (BURST_LEN > 1))
                  w_next = READ_BEATS;
               else
                  w_next = IDLE;
            end
         end
         READ_BEATS: begin
            if (r_beat == LAST_BEAT)
               w_next = IDLE;
         end
         WR_GAP: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // command latch, controller drive and response capture
   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         r_we        <= 1'b0;
         r_burst     <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_sel       <= '0;
         r_ch        <= '0;
         r_beat      <= '0;
         r_ready     <= '0;
         r_acc       <= 1'b0;
         r_sc_we     <= 1'b0;
         r_adr       <= '0;
         r_sc_dat    <= '0;
         r_sc_sel    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_ch    <= '0;
         r_rsp_data  <= '0;
         r_rsp_last  <= 1'b0;
      end else begin
         r_ready     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_last  <= 1'b0;
         if (w_grant) begin
            r_ready <= w_gnt;
            r_we    <= cmd_we_i[w_gidx];
            r_burst <= cmd_burst_i[w_gidx];
            r_addr  <= cmd_addr_i[int'(w_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
            r_data  <= cmd_data_i[int'(w_gidx)*16 +: 16];
            r_sel   <= cmd_sel_i[int'(w_gidx)*2 +: 2];
            r_ch    <= w_gidx;
         end
         if (r_state == ISSUE && sc_idle_i) begin
            r_acc    <= 1'b1;
            r_sc_we  <= r_we;
            r_adr    <= byte_adr(31'(r_addr));
            r_sc_dat <= r_data;
            r_sc_sel <= r_sel;
         end
         if (r_state == WAIT_ACK && sc_ack_i) begin
            r_acc   <= 1'b0;
            r_sc_we <= 1'b0;
            if (w_next == READ_BEATS)
               r_beat <= BW'(1);
            if (!r_we) begin
               r_rsp_valid <= 1'b1;
               r_rsp_data  <= sc_dat_i;
               r_rsp_ch    <= r_ch;
               r_rsp_last  <= (w_next == IDLE);
            end
         end
         if (r_state == READ_BEATS) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= sc_dat_i;
            r_rsp_ch    <= r_ch;
            r_rsp_last  <= (r_beat == LAST_BEAT);
            r_beat      <= r_beat + BW'(1);
         end
      end
   end

   assign cmd_ready_o = r_ready;
   assign sc_acc_o    = r_acc;
   assign sc_we_o     = r_sc_we;
   assign sc_adr_o    = r_adr;
   assign sc_dat_o    = r_sc_dat;
   assign sc_sel_o    = r_sc_sel;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_ch_o    = r_rsp_ch;
   assign rsp_data_o  = r_rsp_data;
   assign rsp_last_o  = r_rsp_last;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Scoreboard bench for sdram_cmd_sequencer.
// Controller model acks after two cycles and streams address-derived data.
module tb_sdram_cmd_sequencer;

   localparam int NCH = 2;
   localparam int AW  = 24;
   localparam int BL  = 8;

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [15:0] dat;
      logic [1:0]  sel;
   } acc_t;

   typedef struct packed {
      logic [0:0]  ch;
      logic [15:0] dat;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NCH-1:0]    cmd_valid_i;
   logic [NCH-1:0]    cmd_ready_o;
   logic [NCH-1:0]    cmd_we_i;
   logic [NCH-1:0]    cmd_burst_i;
   logic [NCH*AW-1:0] cmd_addr_i;
   logic [NCH*16-1:0] cmd_data_i;
   logic [NCH*2-1:0]  cmd_sel_i;
   logic [NCH-1:0]    rsp_alm_full_i;
   logic              rsp_valid_o;
   logic [0:0]        rsp_ch_o;
   logic [15:0]       rsp_data_o;
   logic              rsp_last_o;
   logic              sc_idle_i;
   logic              sc_ack_i;
   logic [15:0]       sc_dat_i;
   logic              sc_acc_o;
   logic              sc_we_o;
   logic [31:0]       sc_adr_o;
   logic [15:0]       sc_dat_o;
   logic [1:0]        sc_sel_o;

   logic          t_valid [NCH];
   logic          t_we    [NCH];
   logic          t_burst [NCH];
   logic [AW-1:0] t_addr  [NCH];
   logic [15:0]   t_data  [NCH];
   logic [1:0]    t_sel   [NCH];

   for (genvar c = 0; c < NCH; c++) begin : g_drv
      assign cmd_valid_i[c]         = t_valid[c];
      assign cmd_we_i[c]            = t_we[c];
      assign cmd_burst_i[c]         = t_burst[c];
      assign cmd_addr_i[c*AW +: AW] = t_addr[c];
      assign cmd_data_i[c*16 +: 16] = t_data[c];
      assign cmd_sel_i[c*2 +: 2]    = t_sel[c];
   end

   sdram_cmd_sequencer #(
      .NUM_CH     (NCH),
      .ADDR_WIDTH (AW),
      .BURST_LEN  (BL)
   ) dut (
      .sdram_clk      (clk),
      .sdram_rst_n    (rst_n),
      .cmd_valid_i    (cmd_valid_i),
      .cmd_ready_o    (cmd_ready_o),
      .cmd_we_i       (cmd_we_i),
      .cmd_burst_i    (cmd_burst_i),
      .cmd_addr_i     (cmd_addr_i),
      .cmd_data_i     (cmd_data_i),
      .cmd_sel_i      (cmd_sel_i),
      .rsp_alm_full_i (rsp_alm_full_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ch_o       (rsp_ch_o),
      .rsp_data_o     (rsp_data_o),
      .rsp_last_o     (rsp_last_o),
      .sc_idle_i      (sc_idle_i),
      .sc_ack_i       (sc_ack_i),
      .sc_dat_i       (sc_dat_i),
      .sc_acc_o       (sc_acc_o),
      .sc_we_o        (sc_we_o),
      .sc_adr_o       (sc_adr_o),
      .sc_dat_o       (sc_dat_o),
      .sc_sel_o       (sc_sel_o)
   );

   acc_t  acc_q[$];
   beat_t rsp_q[$];
   int total = 0;
   int bad = 0;
   int acc_cnt = 0;
   int beats_seen = 0;

   task automatic chk(input string nm,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   task automatic exp_acc(input logic we, input logic [31:0] adr,
                          input logic [15:0] dat, input logic [1:0] sel);
      acc_t e;
      e.we = we;
      e.adr = adr;
      e.dat = dat;
      e.sel = sel;
      acc_q.push_back(e);
   endtask

   task automatic exp_beat(input logic ch, input logic [15:0] dat,
                           input logic last);
      beat_t b;
      b.ch = ch;
      b.dat = dat;
      b.last = last;
      rsp_q.push_back(b);
   endtask

   task automatic issue(input int ch, input logic we, input logic burst,
                        input logic [AW-1:0] addr, input logic [15:0] dat,
                        input logic [1:0] sel);
      int n = 0;
      logic [NCH-1:0] oh = '0;
      oh[ch] = 1'b1;
      t_we[ch] = we;
      t_burst[ch] = burst;
      t_addr[ch] = addr;
      t_data[ch] = dat;
      t_sel[ch] = sel;
      t_valid[ch] = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!cmd_ready_o[ch] && n < 300);
      if (!cmd_ready_o[ch]) begin
         total++;
         bad++;
         $display("FAIL grant_timeout ch%0d: got no ready want ready", ch);
      end else begin
         chk("ready_onehot", cmd_ready_o, oh);
      end
      t_valid[ch] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((acc_q.size() != 0 || rsp_q.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (12) @(negedge clk);
   endtask

   // controller model and access scoreboard
   initial begin
      acc_t e;
      logic we;
      logic [15:0] base;
      sc_ack_i = 1'b0;
      sc_dat_i = 16'hDEAD;
      forever begin
         @(negedge clk);
         if (rst_n && sc_acc_o) begin
            acc_cnt++;
            if (acc_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL acc_unexpected: got adr %0h want none", sc_adr_o);
            end else begin
               e = acc_q.pop_front();
               chk("acc_we", sc_we_o, e.we);
               chk("acc_adr", sc_adr_o, e.adr);
               chk("acc_dat", sc_dat_o, e.dat);
               chk("acc_sel", sc_sel_o, e.sel);
            end
            we = sc_we_o;
            base = sc_adr_o[16:1];
            @(negedge clk);
            @(negedge clk);
            sc_ack_i = 1'b1;
            sc_dat_i = base;
            chk("acc_held", {sc_acc_o, sc_we_o}, {1'b1, we});
            @(negedge clk);
            sc_ack_i = 1'b0;
            chk("acc_drop", {sc_acc_o, sc_we_o}, 2'b00);
            if (!we) begin
               for (int k = 1; k < BL; k++) begin
                  sc_dat_i = base + 16'(k);
                  @(negedge clk);
               end
            end
            sc_dat_i = 16'hDEAD;
         end
      end
   end

   // response monitor
   initial begin
      beat_t b;
      forever begin
         @(negedge clk);
         if (rsp_valid_o) begin
            beats_seen++;
            if (rsp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rsp_unexpected: got %0h want none", rsp_data_o);
            end else begin
               b = rsp_q.pop_front();
               chk("rsp_ch", rsp_ch_o, b.ch);
               chk("rsp_dat", rsp_data_o, b.dat);
               chk("rsp_last", rsp_last_o, b.last);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int base;
      for (int c = 0; c < NCH; c++) begin
         t_valid[c] = 1'b0;
         t_we[c] = 1'b0;
         t_burst[c] = 1'b0;
         t_addr[c] = '0;
         t_data[c] = '0;
         t_sel[c] = '0;
      end
      rsp_alm_full_i = '0;
      sc_idle_i = 1'b1;
      t_valid[0] = 1'b1;
      t_we[0] = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", cmd_ready_o, 2'b00);
      chk("rst_acc", sc_acc_o, 1'b0);
      chk("rst_we", sc_we_o, 1'b0);
      chk("rst_valid", rsp_valid_o, 1'b0);
      chk("rst_last", rsp_last_o, 1'b0);
      chk("rst_adr", sc_adr_o, 32'h0);
      chk("rst_sdat", sc_dat_o, 16'h0);
      chk("rst_sel", sc_sel_o, 2'b00);
      chk("rst_rdat", rsp_data_o, 16'h0);
      chk("rst_rch", rsp_ch_o, 1'b0);
      t_valid[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      exp_acc(1'b1, 32'h0000_0020, 16'hBEEF, 2'b11);
      exp_acc(1'b0, 32'h0000_0080, 16'h1234, 2'b01);
      exp_beat(1'b1, 16'h0040, 1'b1);
      fork
         issue(0, 1'b1, 1'b0, 24'h000010, 16'hBEEF, 2'b11);
         issue(1, 1'b0, 1'b0, 24'h000040, 16'h1234, 2'b01);
         begin
            n = 0;
            do begin
               @(posedge clk);
               n++;
            end while (!sc_ack_i && n < 100);
            chk("ack_seen", sc_ack_i, 1'b1);
            @(negedge clk);
            chk("wr_gap0", cmd_ready_o, 2'b00);
            @(negedge clk);
            chk("wr_gap1", cmd_ready_o, 2'b00);
            @(negedge clk);
            chk("gap_grant", cmd_ready_o, 2'b10);
         end
      join
      drain();

      exp_acc(1'b0, 32'h0000_0200, 16'h0000, 2'b00);
      for (int k = 0; k < BL; k++)
         exp_beat(1'b1, 16'h0100 + 16'(k), k == BL - 1);
      issue(1, 1'b0, 1'b1, 24'h000100, 16'h0000, 2'b00);
      drain();

      exp_acc(1'b1, 32'h0000_2000, 16'hA0A0, 2'b11);
      exp_acc(1'b1, 32'h0000_4000, 16'hB0B0, 2'b10);
      exp_acc(1'b1, 32'h0000_2002, 16'hA1A1, 2'b01);
      exp_acc(1'b1, 32'h0000_4002, 16'hB1B1, 2'b11);
      fork
         begin
            issue(0, 1'b1, 1'b0, 24'h001000, 16'hA0A0, 2'b11);
            issue(0, 1'b1, 1'b0, 24'h001001, 16'hA1A1, 2'b01);
         end
         begin
            issue(1, 1'b1, 1'b0, 24'h002000, 16'hB0B0, 2'b10);
            issue(1, 1'b1, 1'b0, 24'h002001, 16'hB1B1, 2'b11);
         end
      join
      drain();

      rsp_alm_full_i[1] = 1'b1;
      base = acc_cnt;
      exp_acc(1'b1, 32'h0000_0800, 16'h5555, 2'b11);
      exp_acc(1'b0, 32'h0000_0600, 16'h0000, 2'b00);
      exp_beat(1'b1, 16'h0300, 1'b1);
      fork
         issue(1, 1'b0, 1'b0, 24'h000300, 16'h0000, 2'b00);
         begin
            repeat (5) @(negedge clk);
            issue(0, 1'b1, 1'b0, 24'h000400, 16'h5555, 2'b11);
         end
         begin
            repeat (30) @(negedge clk);
            chk("alm_hold", acc_cnt - base, 1);
            rsp_alm_full_i[1] = 1'b0;
         end
      join
      drain();

      sc_idle_i = 1'b0;
      exp_acc(1'b0, 32'h0000_1400, 16'h0000, 2'b00);
      for (int k = 0; k < BL; k++)
         exp_beat(1'b0, 16'h0A00 + 16'(k), k == BL - 1);
      issue(0, 1'b0, 1'b1, 24'h000A00, 16'h0000, 2'b00);
      rsp_alm_full_i[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("idle_hold", sc_acc_o, 1'b0);
      end
      sc_idle_i = 1'b1;
      drain();
      rsp_alm_full_i[0] = 1'b0;

      exp_acc(1'b0, 32'h0000_0180, 16'h0000, 2'b00);
      for (int k = 0; k < 3; k++)
         exp_beat(1'b0, 16'h00C0 + 16'(k), 1'b0);
      base = beats_seen;
      issue(0, 1'b0, 1'b1, 24'h0000C0, 16'h0000, 2'b00);
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (beats_seen < base + 3 && n < 100);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_acc", sc_acc_o, 1'b0);
      chk("mid_rst_valid", rsp_valid_o, 1'b0);
      chk("mid_rst_last", rsp_last_o, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("mid_rst_beats", rsp_q.size(), 0);
      exp_acc(1'b1, 32'h0000_0C00, 16'h6666, 2'b11);
      exp_acc(1'b1, 32'h0000_0E00, 16'h7777, 2'b11);
      fork
         issue(0, 1'b1, 1'b0, 24'h000600, 16'h6666, 2'b11);
         issue(1, 1'b1, 1'b0, 24'h000700, 16'h7777, 2'b11);
      join
      drain();

      chk("acc_q_empty", acc_q.size(), 0);
      chk("rsp_q_empty", rsp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
